apb_regfile_ws: RTL and testbench
=================================

Name: apb_regfile_ws

Overview:
Parametrised APB slave register file, successor to the fixed 8x8-bit write-only register decoder.
- Adds readback, a configurable wait-state generator, per-register read-only protection and registered write-notification pulses.
- Sits behind the APB bridge. Drives configuration registers into the datapath through a flattened register bus.

Parameters:
DATA_W, 8, register and data bus width in bits (1..32)
ADDR_W, 8, paddr width in bits
NUM_REGS, 8, number of registers (1..2^ADDR_W); register k decodes at paddr == k
WAIT_CYCLES, 0, pready-low cycles inserted in every access phase (0..15)
RO_MASK, 0, NUM_REGS-bit mask; bit k set = register k is read-only to APB
RESET_VAL, 0, DATA_W-bit reset value loaded into every register

Ports:
pclk  input  1  APB clock; all state changes on rising edge
preset_n  input  1  asynchronous active-low reset
psel  input  1  slave select
penable  input  1  access-phase indicator
pwrite  input  1  1 = write, 0 = read
paddr  input  ADDR_W  register address
pwdata  input  DATA_W  write data
prdata  output  DATA_W  read data, valid while pready=1
pready  output  1  transfer-complete indication
pslverr  output  1  error response, valid while pready=1
reg_out  output  NUM_REGS*DATA_W  register contents; register k at bits [k*DATA_W +: DATA_W]
reg_wr_pulse  output  NUM_REGS  bit k pulses high one cycle after a successful write to register k

Behaviour:
- Interface: one clock pclk; reset preset_n is asynchronous and active-low.
- Reset (asynchronous on preset_n low):
  - state=IDLE, wait counter=0
  - all registers = RESET_VAL
  - pready=0, pslverr=0, prdata=0, reg_wr_pulse=0
- Reset asserted mid-transfer aborts the transfer; no register is modified after the reset edge.
- FSM states:
  - IDLE: psel=1 and penable=0 (setup) -> SETUP. Anything else stays in IDLE.
  - SETUP: psel=1 -> ACCESS with cnt=0. psel=0 -> IDLE.
  - ACCESS:
    - pready = (cnt == WAIT_CYCLES). While pready=0, cnt increments each cycle.
    - psel=1, penable=1 and pready=1 is the completion cycle; next state is IDLE, or SETUP if psel=1 and penable=0 in the following cycle per normal APB back-to-back.
    - psel dropped while in ACCESS -> IDLE, cnt=0, no write, no error.
- Latency: transfer completes WAIT_CYCLES+1 cycles after the setup cycle. WAIT_CYCLES=0 gives zero-wait APB.
- pready, pslverr and prdata are combinational from state, cnt and the decoded address. They are 0 outside a completion cycle.
- Decode: valid = (paddr < NUM_REGS). Out-of-range addresses are reserved.
- Error rule: pslverr=1 in the completion cycle if the address is not valid, or if pwrite=1 and RO_MASK[paddr]=1. Otherwise pslverr=0.
- Write: on the completion-cycle rising edge with pwrite=1 and no error, reg[paddr] <= pwdata. No other register changes. A write with an error changes nothing.
- Read: prdata = reg[paddr] in the completion cycle if valid. prdata=0 for an out-of-range read, with pslverr=1. Reads of read-only registers are legal.
- paddr, pwrite and pwdata are sampled in the completion cycle. The slave does not latch them at setup, since APB holds them stable.
- reg_wr_pulse: registered. Bit k is high for exactly one cycle after each successful write to register k, including a write of an unchanged value. Back-to-back writes to the same register give one pulse per write.
- Read-only registers hold RESET_VAL permanently.
- reg_out reflects the new value in the cycle after the write edge.
- penable=1 while in IDLE (protocol violation) is ignored; no pready is asserted.

Test Plan:
1. Defaults, zero-wait write/read: write 0xA5 to addr 3, then read addr 3 -> pready high in first access cycle; prdata=0xA5; reg_out[31:24]=0xA5; reg_wr_pulse=8'h08 for one cycle; pslverr=0 throughout.
2. WAIT_CYCLES=3: write 0x3C to addr 0 -> pready low for 3 access cycles, high on the 4th; register updates only on that edge; cnt returns to 0.
3. Error paths, defaults: write 0x55 to addr 0x08 -> pslverr=1 with pready, no register change, reg_wr_pulse=0. Read addr 0xFF -> prdata=0x00, pslverr=1.
4. RO_MASK=8'h04, RESET_VAL=0x11: write 0x99 to addr 2 -> pslverr=1, register stays 0x11. Read addr 2 -> prdata=0x11, pslverr=0.
5. WAIT_CYCLES=2: deassert psel after 1 access cycle during a write of 0x77 to addr 5 -> no write, no pready. Then pull preset_n low mid-wait of a second write -> all registers return to RESET_VAL; FSM is in IDLE and pready=0 immediately.
6. DATA_W=16, NUM_REGS=4: back-to-back writes 0x1234 then 0xBEEF to addr 1, then a read -> two distinct reg_wr_pulse[1] pulses; read returns 0xBEEF.

Source files
------------

// File: rtl/apb_regfile_ws.sv
// APB slave register file with readback, programmable wait states, per-register
// read-only protection and registered write-notification pulses.
module apb_regfile_ws #(
  parameter int unsigned         DATA_W      = 8,
  parameter int unsigned         ADDR_W      = 8,
  parameter int unsigned         NUM_REGS    = 8,
  parameter int unsigned         WAIT_CYCLES = 0,
  parameter logic [NUM_REGS-1:0] RO_MASK     = '0,
  parameter logic [DATA_W-1:0]   RESET_VAL   = '0
) (
  input  logic                         pclk,
  input  logic                         preset_n,
  input  logic                         psel,
  input  logic                         penable,
  input  logic                         pwrite,
  input  logic [ADDR_W-1:0]            paddr,
  input  logic [DATA_W-1:0]            pwdata,
  output logic [DATA_W-1:0]            prdata,
  output logic                         pready,
  output logic                         pslverr,
  output logic [NUM_REGS*DATA_W-1:0]   reg_out,
  output logic [NUM_REGS-1:0]          reg_wr_pulse
);

  // The setup cycle is recognised while idle, so the first access cycle is
  // already StAccess and a zero-wait transfer completes there.
  typedef enum logic [0:0] {StIdle, StAccess} state_e;

  localparam logic [3:0] WaitCnt = 4'(WAIT_CYCLES);

  state_e                state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic [DATA_W-1:0]     regs_q [NUM_REGS];
  logic [NUM_REGS-1:0]   wr_pulse_q;

  logic                  ready;
  logic                  complete;
  logic [NUM_REGS-1:0]   hit;
  logic                  valid;
  logic                  ro_sel;
  logic                  err;
  logic [DATA_W-1:0]     rd_data;
  logic [NUM_REGS-1:0]   wr_hit;

  // State register
  always_ff @(posedge pclk or negedge preset_n) begin
    if (!preset_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign ready    = (cnt_q == WaitCnt);
  assign complete = (state_q == StAccess) && psel && penable && ready;

  // Next-state logic
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (psel && !penable) begin
          state_d = StAccess;
          cnt_d   = '0;
        end
      end
      StAccess: begin
        if (!psel) begin
          state_d = StIdle;
          cnt_d   = '0;
        end else if (!penable) begin
          // A fresh setup phase restarts the wait count.
          cnt_d = '0;
        end else if (ready) begin
          state_d = StIdle;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      default: begin
        state_d = StIdle;
        cnt_d   = '0;
      end
    endcase
  end

  // Address decode; hit is empty for out-of-range addresses.
  always_comb begin
    hit     = '0;
    rd_data = '0;
    ro_sel  = 1'b0;
    for (int k = 0; k < NUM_REGS; k++) begin
      hit[k] = (paddr == ADDR_W'(k));
      if (hit[k]) begin
        rd_data = regs_q[k];
        ro_sel  = RO_MASK[k];
      end
    end
  end

  assign valid  = |hit;
  assign err    = !valid || (pwrite && ro_sel);
  assign wr_hit = hit & {NUM_REGS{complete && pwrite && !err}};

  // Output logic
  always_comb begin
    pready  = complete;
    pslverr = complete && err;
    prdata  = (complete && !pwrite) ? rd_data : '0;
  end

  always_ff @(posedge pclk or negedge preset_n) begin
    if (!preset_n) begin
      for (int k = 0; k < NUM_REGS; k++) begin
        regs_q[k] <= RESET_VAL;
      end
      wr_pulse_q <= '0;
    end else begin
      for (int k = 0; k < NUM_REGS; k++) begin
        if (wr_hit[k]) begin
          regs_q[k] <= pwdata;
        end
      end
      wr_pulse_q <= wr_hit;
    end
  end

  always_comb begin
    reg_out = '0;
    for (int k = 0; k < NUM_REGS; k++) begin
      reg_out[k*DATA_W +: DATA_W] = regs_q[k];
    end
  end

  assign reg_wr_pulse = wr_pulse_q;

endmodule

// File: tb/tb_apb_regfile_ws.sv
// Directed plus randomized APB traffic against a register-array model of the
// register file, with wait-state, error, pulse and reset checks.
module tb_apb_regfile_ws;

  localparam int unsigned      DW = 16;
  localparam int unsigned      AW = 8;
  localparam int unsigned      NR = 6;
  localparam int unsigned      WC = 2;
  localparam logic [NR-1:0]    RO = 6'b000100;
  localparam logic [DW-1:0]    RV = 16'h0011;

  logic             pclk;
  logic             preset_n;
  logic             psel;
  logic             penable;
  logic             pwrite;
  logic [AW-1:0]    paddr;
  logic [DW-1:0]    pwdata;
  logic [DW-1:0]    prdata;
  logic             pready;
  logic             pslverr;
  logic [NR*DW-1:0] reg_out;
  logic [NR-1:0]    reg_wr_pulse;

  apb_regfile_ws #(
    .DATA_W      (DW),
    .ADDR_W      (AW),
    .NUM_REGS    (NR),
    .WAIT_CYCLES (WC),
    .RO_MASK     (RO),
    .RESET_VAL   (RV)
  ) u_dut (
    .pclk         (pclk),
    .preset_n     (preset_n),
    .psel         (psel),
    .penable      (penable),
    .pwrite       (pwrite),
    .paddr        (paddr),
    .pwdata       (pwdata),
    .prdata       (prdata),
    .pready       (pready),
    .pslverr      (pslverr),
    .reg_out      (reg_out),
    .reg_wr_pulse (reg_wr_pulse)
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  int            checks = 0;
  int            errors = 0;
  logic [DW-1:0] model [NR];
  logic [NR-1:0] exp_pulse;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [NR*DW-1:0] flat();
    logic [NR*DW-1:0] f;
    f = '0;
    for (int k = 0; k < NR; k++) f[k*DW +: DW] = model[k];
    return f;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < NR; k++) model[k] = RV;
    exp_pulse = '0;
  endtask

  // Effects of the previous completion edge, seen one cycle later.
  task automatic post_check(input string tag);
    chk({tag, "_pulse"}, 128'(reg_wr_pulse), 128'(exp_pulse));
    chk({tag, "_regout"}, 128'(reg_out), 128'(flat()));
    exp_pulse = '0;
  endtask

  task automatic xfer(input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d,
                      input bit idle_after);
    int       waits;
    logic     valid;
    logic     err;
    logic [2:0] ix;
    @(posedge pclk); #1;
    psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = a; pwdata = d;
    @(negedge pclk);
    post_check("setup");
    chk("setup_pready", 128'(pready), 128'(0));
    @(posedge pclk); #1;
    penable = 1'b1;
    @(negedge pclk);
    chk("access_pulse", 128'(reg_wr_pulse), 128'(0));
    waits = 0;
    while (!pready && waits < 20) begin
      waits++;
      @(negedge pclk);
    end
    ix    = a[2:0];
    valid = (a < AW'(NR));
    err   = valid ? (wr && RO[ix]) : 1'b1;
    chk("wait_cycles", 128'(waits), 128'(WC));
    chk("pready", 128'(pready), 128'(1));
    chk("pslverr", 128'(pslverr), 128'(err));
    if (!wr) chk("prdata", 128'(prdata), valid ? 128'(model[ix]) : 128'(0));
    if (wr && !err) begin
      model[ix] = d;
      exp_pulse = NR'(1) << ix;
    end
    if (idle_after) begin
      @(posedge pclk); #1;
      psel = 1'b0; penable = 1'b0;
      @(negedge pclk);
      post_check("idle");
      chk("idle_pready", 128'(pready), 128'(0));
    end
  endtask

  initial begin
    logic [AW-1:0] ra;
    logic [DW-1:0] rd;
    preset_n = 1'b0; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    paddr = '0; pwdata = '0;
    model_reset();
    #12;
    chk("rst_pready", 128'(pready), 128'(0));
    chk("rst_pslverr", 128'(pslverr), 128'(0));
    chk("rst_prdata", 128'(prdata), 128'(0));
    chk("rst_pulse", 128'(reg_wr_pulse), 128'(0));
    chk("rst_regout", 128'(reg_out), 128'(flat()));
    @(negedge pclk); preset_n = 1'b1;

    // Write then read back, in-range boundaries and error paths.
    xfer(1'b1, 8'd3, 16'h00A5, 1'b1);
    xfer(1'b0, 8'd3, 16'h0000, 1'b1);
    xfer(1'b1, 8'd6, 16'h0055, 1'b1);
    xfer(1'b1, 8'h08, 16'h0055, 1'b1);
    xfer(1'b0, 8'hFF, 16'h0000, 1'b1);
    xfer(1'b1, 8'd5, 16'hCAFE, 1'b1);
    xfer(1'b0, 8'd5, 16'h0000, 1'b1);
    xfer(1'b1, 8'd2, 16'h0099, 1'b1);
    xfer(1'b0, 8'd2, 16'h0000, 1'b1);

    // Back-to-back writes to one register, then same-value rewrite.
    xfer(1'b1, 8'd1, 16'h1234, 1'b0);
    xfer(1'b1, 8'd1, 16'hBEEF, 1'b0);
    xfer(1'b1, 8'd1, 16'hBEEF, 1'b0);
    xfer(1'b0, 8'd1, 16'h0000, 1'b1);

    // penable high while idle must not start a transfer.
    @(posedge pclk); #1;
    psel = 1'b1; penable = 1'b1; pwrite = 1'b1; paddr = 8'd0; pwdata = 16'hDEAD;
    for (int i = 0; i < 4; i++) begin
      @(negedge pclk);
      chk("idle_penable_pready", 128'(pready), 128'(0));
    end
    @(posedge pclk); #1;
    psel = 1'b0; penable = 1'b0;
    @(negedge pclk);
    post_check("idle_penable");

    // psel dropped mid-wait aborts the write.
    @(posedge pclk); #1;
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 8'd5; pwdata = 16'h0077;
    @(posedge pclk); #1;
    penable = 1'b1;
    @(negedge pclk);
    chk("abort_wait_pready", 128'(pready), 128'(0));
    @(posedge pclk); #1;
    psel = 1'b0; penable = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge pclk);
      chk("abort_pready", 128'(pready), 128'(0));
      post_check("abort");
    end
    xfer(1'b0, 8'd5, 16'h0000, 1'b1);

    // Randomized traffic.
    for (int i = 0; i < 60; i++) begin
      ra = ($urandom_range(0, 7) == 0) ? AW'($urandom) : AW'($urandom_range(0, NR));
      rd = DW'($urandom);
      xfer(1'($urandom_range(0, 1)), ra, rd, 1'($urandom_range(0, 1)));
    end
    xfer(1'b1, 8'd4, 16'h4444, 1'b1);

    // Reset in the middle of a waited write.
    @(posedge pclk); #1;
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 8'd0; pwdata = 16'h5A5A;
    @(posedge pclk); #1;
    penable = 1'b1;
    @(negedge pclk);
    #2 preset_n = 1'b0;
    #1;
    model_reset();
    chk("midrst_pready", 128'(pready), 128'(0));
    chk("midrst_pslverr", 128'(pslverr), 128'(0));
    chk("midrst_regout", 128'(reg_out), 128'(flat()));
    chk("midrst_pulse", 128'(reg_wr_pulse), 128'(0));
    psel = 1'b0; penable = 1'b0;
    @(negedge pclk);
    preset_n = 1'b1;
    @(negedge pclk);
    post_check("after_rst");
    for (int k = 0; k < NR; k++) xfer(1'b0, AW'(k), 16'h0000, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed running expected finished");
    $fatal(1, "timeout");
  end

endmodule
